// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared state encoding and default sizes for count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package count_seq_pkg;

    localparam int unsigned c_DEF_WIDTH    = 4;
    localparam int unsigned c_DEF_RELOAD_W = 8;
    localparam logic [c_DEF_RELOAD_W-1:0] c_RELOAD_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/count_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_core
// Description : Counter with clear/enable and terminal-value compare.
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_core
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] count,
    output logic             eq_lim
);

    logic [WIDTH-1:0] r_count;

    // clr wins over en so an auto-reload terminal cycle returns to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count  = r_count;
    assign eq_lim = (r_count == lim);

endmodule
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Run controller (start/hold/abort, one-shot or auto-reload)
//               around the count_seq_core counter.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = c_DEF_WIDTH,
    parameter int unsigned RELOAD_W = c_DEF_RELOAD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    limit,
    input  logic                auto_reload,
    input  logic                hold,
    input  logic                abort,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                tc_pulse,
    output logic                done,
    output logic [RELOAD_W-1:0] reload_cnt
);

    localparam logic [RELOAD_W-1:0] c_SAT = {RELOAD_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_lim;
    logic                r_mode;
    logic [RELOAD_W-1:0] r_reload_cnt;
    logic                r_busy;
    logic                r_done;

    logic                w_start_acc;
    logic                w_tc;
    logic                w_clr;
    logic                w_en;
    logic                w_reload_inc;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_eq_lim;
    logic [WIDTH-1:0]    w_count;

    count_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_en),
        .lim    (r_lim),
        .count  (w_count),
        .eq_lim (w_eq_lim)
    );

    // busy/done are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lim        <= '0;
            r_mode       <= 1'b0;
            r_reload_cnt <= '0;
        end else if (w_start_acc) begin
            r_lim        <= limit;
            r_mode       <= auto_reload;
            r_reload_cnt <= '0;
        end else if (w_reload_inc && (r_reload_cnt != c_SAT)) begin
            r_reload_cnt <= r_reload_cnt + RELOAD_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = abort ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (hold) begin
                    w_state_nxt = S_HOLD;
                end else if (w_eq_lim && !r_mode) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (!hold) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_start_acc  = (r_state == S_IDLE) && start;
        w_tc         = (r_state == S_RUN) && w_eq_lim && !abort && !hold;
        w_reload_inc = w_tc && r_mode;
        w_clr        = w_start_acc || w_reload_inc;
        w_en         = (r_state == S_RUN) && !abort && !hold && !w_eq_lim;
        w_busy_nxt   = (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN) ||
                       (w_state_nxt == S_HOLD);
        w_done_nxt   = (w_state_nxt == S_DONE);
    end

    assign count      = w_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign tc_pulse   = w_tc;
    assign reload_cnt = r_reload_cnt;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sequencer
// Description : Vector table, directed sequences and randomized run against
//               a behavioural model of count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] limit;
    logic       auto_reload;
    logic       hold;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc_pulse;
    logic       done;
    logic [7:0] reload_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       st;
        logic [3:0] lim;
        logic       ar;
        logic       hd;
        logic       ab;
        logic [3:0] e_cnt;
        logic       e_busy;
        logic       e_done;
        logic       e_tc;
        logic [7:0] e_rl;
    } vec_t;

    vec_t vecs[$];

    count_sequencer #(
        .WIDTH    (4),
        .RELOAD_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .limit       (limit),
        .auto_reload (auto_reload),
        .hold        (hold),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .tc_pulse    (tc_pulse),
        .done        (done),
        .reload_cnt  (reload_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(logic st, logic [3:0] lim, logic ar, logic hd, logic ab,
                               logic [3:0] ec, logic eb, logic ed, logic et, logic [7:0] er);
        vec_t x;
        x.st = st; x.lim = lim; x.ar = ar; x.hd = hd; x.ab = ab;
        x.e_cnt = ec; x.e_busy = eb; x.e_done = ed; x.e_tc = et; x.e_rl = er;
        return x;
    endfunction

    task automatic drive(input logic rn, input logic st, input logic [3:0] lim,
                         input logic ar, input logic hd, input logic ab);
        rst = rn; start = st; limit = lim; auto_reload = ar; hold = hd; abort = ab;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [3:0] ec, input logic eb,
                           input logic ed, input logic et, input logic [7:0] er);
        n_chk++;
        if ({count, busy, done, tc_pulse, reload_cnt} !== {ec, eb, ed, et, er}) begin
            n_err++;
            $display("FAIL %s @%0t: got cnt=%0d busy=%0b done=%0b tc=%0b rl=%0d, want cnt=%0d busy=%0b done=%0b tc=%0b rl=%0d",
                     name, $time, count, busy, done, tc_pulse, reload_cnt, ec, eb, ed, et, er);
        end
    endtask

    // behavioural model state
    bit m_arm, m_run, m_pause, m_end, m_mode;
    int m_cnt, m_lim, m_rl;

    initial begin
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // one-shot limit 5; limit/mode changes while busy ignored
        vecs.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 9, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k <= 5; k++)
            vecs.push_back(v(0, 9, 1, 0, 0, 4'(k), 1, 0, (k == 5), 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        // abort on the terminal cycle, start in DONE ignored
        vecs.push_back(v(1, 4, 0, 0, 0, 5, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k <= 3; k++)
            vecs.push_back(v(0, 0, 0, 0, 0, 4'(k), 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 4, 1, 0, 0, 0));
        vecs.push_back(v(1, 7, 0, 0, 0, 4, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        // hold high three cycles at count 2
        vecs.push_back(v(1, 5, 0, 0, 0, 4, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        // hold on the terminal cycle defers tc past release
        vecs.push_back(v(1, 2, 0, 0, 0, 5, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].st, vecs[i].lim, vecs[i].ar, vecs[i].hd, vecs[i].ab);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_tc, vecs[i].e_rl);
            next_cycle();
        end

        // auto-reload limit 3 for 20 RUN cycles
        drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_out("ar3_arm", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            chk_out("ar3_run", 4'(k % 4), 1'b1, 1'b0, (k % 4 == 3), 8'(k / 4));
            next_cycle();
        end
        abort = 1'b1;
        #1;
        chk_out("ar3_abort", 4'd0, 1'b1, 1'b0, 1'b0, 8'd5);
        next_cycle();
        abort = 1'b0;
        chk_out("ar3_done", 4'd0, 1'b0, 1'b1, 1'b0, 8'd5);
        next_cycle();

        // limit 0 auto-reload: tc every cycle, reload saturates, starts ignored
        drive(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_out("lim0_arm", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        next_cycle();
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
            #1;
            chk_out("lim0_run", 4'd0, 1'b1, 1'b0, 1'b1, 8'((k > 255) ? 255 : k));
            next_cycle();
        end
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_out("lim0_done", 4'd0, 1'b0, 1'b1, 1'b0, 8'd255);
        next_cycle();

        // reset mid-run at count 6
        drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (7) next_cycle();
        rst = 1'b0;
        #1;
        chk_out("rst_pre", 4'd6, 1'b1, 1'b0, 1'b0, 8'd0);
        next_cycle();
        rst = 1'b1;
        chk_out("rst_post", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        next_cycle();
        chk_out("rst_idle", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // randomized run against the model
        m_arm = 0; m_run = 0; m_pause = 0; m_end = 0; m_mode = 0;
        m_cnt = 0; m_lim = 0; m_rl = 0;
        for (int i = 0; i < 2000; i++) begin
            logic rn, st, ar, hd, ab, e_tc;
            logic [3:0] lim;
            rn  = ($urandom_range(0, 199) != 0);
            st  = ($urandom_range(0, 2) == 0);
            lim = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            ar  = 1'($urandom_range(0, 1));
            hd  = ($urandom_range(0, 5) == 0);
            ab  = ($urandom_range(0, 31) == 0);
            drive(rn, st, lim, ar, hd, ab);
            #1;
            e_tc = m_run && (m_cnt == m_lim) && !ab && !hd;
            chk_out("random", 4'(m_cnt), m_arm | m_run | m_pause, m_end, e_tc, 8'(m_rl));

            if (!rn) begin
                m_arm = 0; m_run = 0; m_pause = 0; m_end = 0; m_cnt = 0; m_rl = 0;
            end else if (m_end) begin
                m_end = 0;
            end else if (m_arm) begin
                m_arm = 0;
                if (ab) m_end = 1; else m_run = 1;
            end else if (m_run) begin
                if (ab) begin
                    m_run = 0; m_end = 1;
                end else if (hd) begin
                    m_run = 0; m_pause = 1;
                end else if (m_cnt == m_lim) begin
                    if (m_mode) begin
                        m_cnt = 0;
                        if (m_rl < 255) m_rl++;
                    end else begin
                        m_run = 0; m_end = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end else if (m_pause) begin
                if (ab) begin
                    m_pause = 0; m_end = 1;
                end else if (!hd) begin
                    m_pause = 0; m_run = 1;
                end
            end else if (st) begin
                m_lim = int'(lim); m_mode = ar; m_cnt = 0; m_rl = 0; m_arm = 1;
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
